// File: rtl/apb3_master_param_pkg.sv
// Shared types for the APB3 master: FSM state encoding and the buffered response record.
// The response record is sized for the widest supported data bus; narrower buses zero-extend.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int RSP_DATA_W = 32;

    typedef struct packed {
        logic [RSP_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

    localparam apb_rsp_t RSP_CLEAR = '{rdata: '0, err: 1'b0, timeout: 1'b0};

    function automatic apb_rsp_t make_rsp(input logic [RSP_DATA_W-1:0] rdata,
                                          input logic                  err,
                                          input logic                  timeout);
        apb_rsp_t r;
        r.rdata   = rdata;
        r.err     = err;
        r.timeout = timeout;
        return r;
    endfunction

endpackage

// File: rtl/apb3_master_param_if.sv
// Bundles for the APB3 master: the command/response port toward the front end
// and the APB3 bus toward the slave fabric.
interface apb3_cmd_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    // Front end issuing commands
    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout
    );

    // Bus master consuming commands
    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout
    );
endinterface

interface apb3_bus_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb3_master_param_timeout_cnt.sv
// Counts ACCESS cycles with pready low and flags the cycle on which the transfer must abort.
// A TIMEOUT_CYC of 0 removes the counter entirely and never expires.
module apb_timeout_cnt #(
    parameter int TIMEOUT_CYC = 256
) (
    input  logic pclk,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT_CYC == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge pclk or negedge rstn) begin
                if (!rstn) begin
                    cnt_reg <= '0;
                end else if (clear) begin
                    cnt_reg <= '0;
                end else if (enable) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            // Expiry is flagged while the last permitted wait cycle is in progress
            assign expired = enable && (cnt_reg == CNT_W'(TIMEOUT_CYC - 1));
        end
    endgenerate

endmodule

// File: rtl/apb3_master_param.sv
// APB3 master: one SETUP/ACCESS transfer per accepted command, with a 1-deep
// response buffer and an optional abort for slaves that never assert pready.
module apb3_master_param
    import apb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic        pclk,
    input  logic        rstn,
    apb3_cmd_if.slave   cmd,
    apb3_bus_if.master  apb
);

    apb_state_e        state_reg;
    apb_rsp_t          rsp_reg;
    logic              rsp_valid_reg;
    logic              psel_reg;
    logic              penable_reg;
    logic              pwrite_reg;
    logic [ADDR_W-1:0] paddr_reg;
    logic [DATA_W-1:0] pwdata_reg;

    logic              cmd_fire;
    logic              cnt_clear;
    logic              cnt_enable;
    logic              cnt_expired;

    // A pending response being drained this cycle frees the buffer for a new command
    assign cmd.cmd_ready = (state_reg == IDLE) && (!rsp_valid_reg || cmd.rsp_ready);
    assign cmd_fire      = cmd.cmd_valid && cmd.cmd_ready;

    assign cnt_clear  = (state_reg != ACCESS);
    assign cnt_enable = (state_reg == ACCESS) && !apb.pready;

    apb_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout_cnt (
        .pclk    (pclk),
        .rstn    (rstn),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .expired (cnt_expired)
    );

    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            rsp_reg       <= RSP_CLEAR;
            rsp_valid_reg <= 1'b0;
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
            pwrite_reg    <= 1'b0;
            paddr_reg     <= '0;
            pwdata_reg    <= '0;
        end else begin
            if (rsp_valid_reg && cmd.rsp_ready) begin
                rsp_valid_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (cmd_fire) begin
                        state_reg   <= SETUP;
                        psel_reg    <= 1'b1;
                        penable_reg <= 1'b0;
                        pwrite_reg  <= cmd.cmd_write;
                        paddr_reg   <= cmd.cmd_addr;
                        pwdata_reg  <= cmd.cmd_wdata;
                    end
                end

                SETUP: begin
                    state_reg   <= ACCESS;
                    penable_reg <= 1'b1;
                end

                ACCESS: begin
                    // A slave completing on the expiry cycle still counts as a normal finish
                    if (apb.pready) begin
                        state_reg     <= IDLE;
                        psel_reg      <= 1'b0;
                        penable_reg   <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_reg       <= make_rsp(pwrite_reg ? {RSP_DATA_W{1'b0}}
                                                             : RSP_DATA_W'(apb.prdata),
                                                  apb.pslverr, 1'b0);
                    end else if (cnt_expired) begin
                        state_reg     <= IDLE;
                        psel_reg      <= 1'b0;
                        penable_reg   <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_reg       <= make_rsp({RSP_DATA_W{1'b0}}, 1'b1, 1'b1);
                    end
                end

                default: begin
                    state_reg   <= IDLE;
                    psel_reg    <= 1'b0;
                    penable_reg <= 1'b0;
                end
            endcase
        end
    end

    assign apb.psel    = psel_reg;
    assign apb.penable = penable_reg;
    assign apb.pwrite  = pwrite_reg;
    assign apb.paddr   = paddr_reg;
    assign apb.pwdata  = pwdata_reg;

    assign cmd.rsp_valid   = rsp_valid_reg;
    assign cmd.rsp_rdata   = rsp_reg.rdata[DATA_W-1:0];
    assign cmd.rsp_err     = rsp_reg.err;
    assign cmd.rsp_timeout = rsp_reg.timeout;

endmodule
